// File: rtl/nonoverlap_clkgen_multi.sv
// Programmable non-overlapping MOD/MODN clock pair with NUM_LAG phase-shifted MOD copies.
// Half-period, dead time and phases go through a shadow register and change only at a wrap.
module nonoverlap_clkgen_multi #(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned NUM_LAG   = 1,
  parameter int unsigned DEF_HALF  = 8,
  parameter int unsigned DEF_DEAD  = 2,
  parameter int unsigned DEF_PHASE = 8
) (
  input  logic                       CLK_IN,
  input  logic                       RESET,
  input  logic                       ENABLE,
  input  logic                       CFG_VALID,
  output logic                       CFG_READY,
  input  logic [CNT_W-1:0]           CFG_HALF,
  input  logic [CNT_W-1:0]           CFG_DEAD,
  input  logic [NUM_LAG*CNT_W-1:0]   CFG_PHASE,
  output logic                       CLK_OUT_MOD,
  output logic                       CLK_OUT_MODN,
  output logic [NUM_LAG-1:0]         CLK_OUT_MODL,
  output logic                       RUNNING,
  output logic                       CFG_ERR
);

  localparam int unsigned CW = CNT_W + 1;
  localparam logic [CNT_W-1:0] DefHalf  = CNT_W'(DEF_HALF);
  localparam logic [CNT_W-1:0] DefDead  = CNT_W'(DEF_DEAD);
  localparam logic [CNT_W-1:0] DefPhase = CNT_W'(DEF_PHASE);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e                     state_q, state_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [CNT_W-1:0]           half_q, dead_q;
  logic [NUM_LAG*CNT_W-1:0]   phase_q;
  logic                       sh_full_q;
  logic [CNT_W-1:0]           sh_half_q, sh_dead_q;
  logic [NUM_LAG*CNT_W-1:0]   sh_phase_q;
  logic                       mod_q, modn_q, running_q, err_q;
  logic [NUM_LAG-1:0]         modl_q;

  logic [CW-1:0]              period, cfg_period, half_ext, dead_ext, lag_pos;
  logic [CW:0]                lag_diff;
  logic                       wrap, xfer, apply, cfg_legal, gate;
  logic                       mod_d, modn_d;
  logic [NUM_LAG-1:0]         modl_d;

  assign period     = {half_q, 1'b0};
  assign cfg_period = {CFG_HALF, 1'b0};
  assign half_ext   = {1'b0, half_q};
  assign dead_ext   = {1'b0, dead_q};
  assign wrap       = (cnt_q == period - CW'(1));
  assign xfer       = CFG_VALID & ~sh_full_q;
  // Shadow and transfer are mutually exclusive: a transfer needs an empty shadow.
  assign apply      = sh_full_q & ((state_q == StIdle) | wrap);

  always_comb begin
    cfg_legal = (CFG_HALF != '0) && (CFG_DEAD < CFG_HALF);
    for (int unsigned i = 0; i < NUM_LAG; i++) begin
      if ({1'b0, CFG_PHASE[i*CNT_W +: CNT_W]} >= cfg_period) begin
        cfg_legal = 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (ENABLE) state_d = StRun;
      end
      StRun: begin
        cnt_d = wrap ? '0 : cnt_q + CW'(1);
        if (!ENABLE) state_d = StDrain;
      end
      StDrain: begin
        cnt_d = wrap ? '0 : cnt_q + CW'(1);
        if (ENABLE)    state_d = StRun;
        else if (wrap) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are silent in IDLE and from the edge that ends a drain.
  always_comb begin
    gate     = (state_q != StIdle) && (state_d != StIdle);
    mod_d    = gate && (cnt_q >= dead_ext) && (cnt_q < half_ext);
    modn_d   = gate && (cnt_q >= half_ext + dead_ext) && (cnt_q < period);
    lag_diff = '0;
    lag_pos  = '0;
    modl_d   = '0;
    for (int unsigned i = 0; i < NUM_LAG; i++) begin
      lag_diff  = {1'b0, cnt_q} - {2'b00, phase_q[i*CNT_W +: CNT_W]};
      lag_pos   = lag_diff[CW] ? lag_diff[CW-1:0] + period : lag_diff[CW-1:0];
      modl_d[i] = gate && (lag_pos >= dead_ext) && (lag_pos < half_ext);
    end
  end

  always_ff @(posedge CLK_IN) begin
    if (RESET) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      half_q     <= DefHalf;
      dead_q     <= DefDead;
      phase_q    <= {NUM_LAG{DefPhase}};
      sh_full_q  <= 1'b0;
      sh_half_q  <= '0;
      sh_dead_q  <= '0;
      sh_phase_q <= '0;
      mod_q      <= 1'b0;
      modn_q     <= 1'b0;
      modl_q     <= '0;
      running_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mod_q     <= mod_d;
      modn_q    <= modn_d;
      modl_q    <= modl_d;
      running_q <= (state_q != StIdle);
      err_q     <= xfer & ~cfg_legal;
      if (apply) begin
        half_q  <= sh_half_q;
        dead_q  <= sh_dead_q;
        phase_q <= sh_phase_q;
      end
      if (xfer && cfg_legal) begin
        sh_full_q  <= 1'b1;
        sh_half_q  <= CFG_HALF;
        sh_dead_q  <= CFG_DEAD;
        sh_phase_q <= CFG_PHASE;
      end else if (apply) begin
        sh_full_q <= 1'b0;
      end
    end
  end

  assign CFG_READY    = ~sh_full_q;
  assign CLK_OUT_MOD  = mod_q;
  assign CLK_OUT_MODN = modn_q;
  assign CLK_OUT_MODL = modl_q;
  assign RUNNING      = running_q;
  assign CFG_ERR      = err_q;

endmodule

// File: tb/tb_nonoverlap_clkgen_multi.sv
// Bench for nonoverlap_clkgen_multi: cycle model feeding a scoreboard plus directed scenario tasks.
module tb_nonoverlap_clkgen_multi;

  localparam int CW = 16;
  localparam int NL = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            en  = 1'b0;
  logic            cv  = 1'b0;
  logic [CW-1:0]   ch  = '0;
  logic [CW-1:0]   cd  = '0;
  logic [NL*CW-1:0] cp = '0;
  logic            ready, mod, modn, running, err;
  logic [NL-1:0]   modl;

  int checks   = 0;
  int failures = 0;
  logic [6:0] sb[$];
  logic [6:0] sb_want;

  nonoverlap_clkgen_multi #(
    .CNT_W    (CW),
    .NUM_LAG  (NL),
    .DEF_HALF (8),
    .DEF_DEAD (2),
    .DEF_PHASE(8)
  ) dut (
    .CLK_IN      (clk),
    .RESET       (rst),
    .ENABLE      (en),
    .CFG_VALID   (cv),
    .CFG_READY   (ready),
    .CFG_HALF    (ch),
    .CFG_DEAD    (cd),
    .CFG_PHASE   (cp),
    .CLK_OUT_MOD (mod),
    .CLK_OUT_MODN(modn),
    .CLK_OUT_MODL(modl),
    .RUNNING     (running),
    .CFG_ERR     (err)
  );

  always #5 clk = ~clk;

  // Bit order: {MOD, MODN, MODL[1], MODL[0], RUNNING, CFG_ERR, CFG_READY}
  function automatic logic [6:0] cur();
    return {mod, modn, modl, running, err, ready};
  endfunction

  // True when (c - p) mod 2h lies in [d, h-1].
  function automatic bit in_win(int c, int h, int d, int p);
    int per, r;
    per = 2 * h;
    r   = ((c - p) % per + per) % per;
    return (r >= d) && (r < h);
  endfunction

  int   m_st, m_cnt, m_h, m_d, m_nst, m_ncnt, m_per, s_h, s_d;
  int   m_p[NL];
  int   s_p[NL];
  bit   m_sh, m_wrap, m_xfer, m_legal, m_gate;
  logic [6:0] m_want;

  // Reference model: one expected output vector per rising edge.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_st = 0; m_cnt = 0; m_h = 8; m_d = 2; m_sh = 0;
        for (int i = 0; i < NL; i++) m_p[i] = 8;
        m_want = 7'b0000001;
      end else begin
        m_per   = 2 * m_h;
        m_wrap  = (m_cnt == m_per - 1);
        m_xfer  = cv && !m_sh;
        m_legal = (ch >= 1) && (cd < ch);
        for (int i = 0; i < NL; i++)
          if (int'(cp[i*CW +: CW]) >= 2 * int'(ch)) m_legal = 0;
        m_nst  = m_st;
        m_ncnt = m_cnt;
        if (m_st == 0) begin
          if (en) m_nst = 1;
        end else begin
          m_ncnt = m_wrap ? 0 : m_cnt + 1;
          if (m_st == 1 && !en) m_nst = 2;
          if (m_st == 2) m_nst = en ? 1 : (m_wrap ? 0 : 2);
        end
        m_gate    = (m_st != 0) && (m_nst != 0);
        m_want    = '0;
        m_want[6] = m_gate && in_win(m_cnt, m_h, m_d, 0);
        m_want[5] = m_gate && in_win(m_cnt, m_h, m_d, m_h);
        for (int i = 0; i < NL; i++) m_want[3+i] = m_gate && in_win(m_cnt, m_h, m_d, m_p[i]);
        m_want[2] = (m_st != 0);
        m_want[1] = m_xfer && !m_legal;
        if (m_sh && (m_st == 0 || m_wrap)) begin
          m_h = s_h; m_d = s_d; m_sh = 0;
          for (int i = 0; i < NL; i++) m_p[i] = s_p[i];
        end
        if (m_xfer && m_legal) begin
          s_h = int'(ch); s_d = int'(cd); m_sh = 1;
          for (int i = 0; i < NL; i++) s_p[i] = int'(cp[i*CW +: CW]);
        end
        m_want[0] = !m_sh;
        m_st  = m_nst;
        m_cnt = m_ncnt;
      end
      sb.push_back(m_want);
    end
  end

  // Scoreboard consumer and overlap monitor.
  initial begin
    forever begin
      @(negedge clk);
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL scoreboard_empty t=%0t", $time);
      end else begin
        sb_want = sb.pop_front();
        if (cur() !== sb_want) begin
          failures++;
          $display("FAIL scoreboard t=%0t got=%b want=%b", $time, cur(), sb_want);
        end
      end
      checks++;
      if (mod === 1'b1 && modn === 1'b1) begin
        failures++;
        $display("FAIL overlap t=%0t got mod=1 modn=1 want not both", $time);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t got no finish want finish", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (cur() !== 7'b0000001) begin
      failures++; $display("FAIL reset_state got=%b want=0000001", cur());
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (cur() !== 7'b0000001) begin
      failures++; $display("FAIL idle_after_reset got=%b want=0000001", cur());
    end
  endtask

  // ENABLE is first high in cycle t (this negedge); negedge k samples cycle t+k.
  task automatic test_default_run();
    logic [6:0] o;
    @(negedge clk);
    en = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      o = cur();
      checks++;
      if (o[2] !== (k >= 2)) begin
        failures++; $display("FAIL default_running k=%0d got=%b want=%b", k, o[2], k >= 2);
      end
      checks++;
      if (o[6] !== (k >= 4 && k <= 9)) begin
        failures++; $display("FAIL default_mod k=%0d got=%b want=%b", k, o[6], k >= 4 && k <= 9);
      end
      checks++;
      if (o[5] !== (k >= 12 && k <= 17) || o[4:3] !== {2{k >= 12 && k <= 17}}) begin
        failures++;
        $display("FAIL default_modn_modl k=%0d got=%b want=%b", k, o[5:3], {3{k >= 12 && k <= 17}});
      end
    end
  endtask

  task automatic test_cfg_change();
    logic [6:0] o, p;
    int wait_rdy, last_mod, prev_mod, last_l0, mod_cnt, modn_cnt;
    @(negedge clk);
    cv = 1'b1; ch = 16'd4; cd = 16'd1; cp = {16'd5, 16'd2};
    @(negedge clk);
    cv = 1'b0;
    o = cur();
    checks++;
    if (o[1:0] !== 2'b00) begin
      failures++; $display("FAIL cfg_accept got err,rdy=%b want 00", o[1:0]);
    end
    wait_rdy = -1; last_mod = -100; prev_mod = -100; last_l0 = -100;
    mod_cnt = 0; modn_cnt = 0; p = o;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      o = cur();
      if (wait_rdy < 0 && o[0]) wait_rdy = k;
      if (k <= 38 && o[6] && !p[6]) begin prev_mod = last_mod; last_mod = k; end
      if (o[3] && !p[3]) last_l0 = k;
      if (k > 32) begin mod_cnt += int'(o[6]); modn_cnt += int'(o[5]); end
      p = o;
    end
    checks++;
    if (wait_rdy < 1 || wait_rdy > 16) begin
      failures++; $display("FAIL cfg_apply_wait got=%0d want 1..16", wait_rdy);
    end
    checks++;
    if (last_mod - prev_mod != 8) begin
      failures++; $display("FAIL cfg_period got=%0d want=8", last_mod - prev_mod);
    end
    checks++;
    if (last_l0 - last_mod != 2) begin
      failures++; $display("FAIL cfg_lag0_offset got=%0d want=2", last_l0 - last_mod);
    end
    checks++;
    if (mod_cnt != 3 || modn_cnt != 3) begin
      failures++; $display("FAIL cfg_duty got mod=%0d modn=%0d want 3 3", mod_cnt, modn_cnt);
    end
  endtask

  task automatic test_illegal();
    int mod_cnt;
    for (int v = 0; v < 2; v++) begin
      @(negedge clk);
      cv = 1'b1; ch = 16'd4;
      cd = (v == 0) ? 16'd4 : 16'd1;
      cp = (v == 0) ? {16'd0, 16'd0} : {16'd0, 16'd8};
      @(negedge clk);
      cv = 1'b0;
      checks++;
      if (err !== 1'b1 || ready !== 1'b1) begin
        failures++; $display("FAIL illegal_pulse v=%0d got err,rdy=%b%b want 11", v, err, ready);
      end
      @(negedge clk);
      checks++;
      if (err !== 1'b0 || ready !== 1'b1) begin
        failures++; $display("FAIL illegal_end v=%0d got err,rdy=%b%b want 01", v, err, ready);
      end
    end
    mod_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      mod_cnt += int'(mod);
    end
    checks++;
    if (mod_cnt != 6) begin
      failures++; $display("FAIL illegal_unchanged got mod_cnt=%0d want=6", mod_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int held, wait_rdy, mod_cnt, modn_cnt;
    bit acc;
    @(negedge clk);
    cv = 1'b1; ch = 16'd6; cd = 16'd2; cp = {16'd4, 16'd3};
    @(negedge clk);
    checks++;
    if (ready !== 1'b0) begin
      failures++; $display("FAIL b2b_first_ready got=%b want=0", ready);
    end
    ch = 16'd5; cd = 16'd0; cp = {16'd9, 16'd1};
    held = 0; acc = 0;
    for (int k = 0; k < 100 && !acc; k++) begin
      @(negedge clk);
      if (ready) acc = 1;
      else held++;
    end
    checks++;
    if (!acc || held < 1 || held > 10) begin
      failures++; $display("FAIL b2b_holdoff got acc=%0d held=%0d want 1 and 1..10", acc, held);
    end
    @(negedge clk);
    cv = 1'b0;
    checks++;
    if (ready !== 1'b0) begin
      failures++; $display("FAIL b2b_second_ready got=%b want=0", ready);
    end
    wait_rdy = -1;
    for (int k = 1; k <= 40 && wait_rdy < 0; k++) begin
      @(negedge clk);
      if (ready) wait_rdy = k;
    end
    checks++;
    if (wait_rdy < 0 || wait_rdy > 12) begin
      failures++; $display("FAIL b2b_second_apply got=%0d want 1..12", wait_rdy);
    end
    repeat (2) @(negedge clk);
    mod_cnt = 0; modn_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      mod_cnt += int'(mod); modn_cnt += int'(modn);
    end
    checks++;
    if (mod_cnt != 5 || modn_cnt != 5) begin
      failures++; $display("FAIL b2b_duty got mod=%0d modn=%0d want 5 5", mod_cnt, modn_cnt);
    end
  endtask

  task automatic test_drain();
    logic [6:0] o, p, pp;
    int fall, rise, mod_cnt;
    bit run_ok;
    @(negedge clk);
    en = 1'b0;
    p = cur(); pp = p; fall = -1;
    for (int k = 1; k <= 40 && fall < 0; k++) begin
      @(negedge clk);
      o = cur();
      if (!o[2]) fall = k;
      else begin pp = p; p = o; end
    end
    checks++;
    if (fall < 0 || p[6:3] !== 4'b0000 || o[6:3] !== 4'b0000 || pp[5] !== 1'b1) begin
      failures++;
      $display("FAIL drain_end got fall=%0d prev=%b last=%b pre2_modn=%b want >=0 0000 0000 1",
               fall, p[6:3], o[6:3], pp[5]);
    end
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (cur() !== 7'b0000001) begin
        failures++; $display("FAIL drain_idle got=%b want=0000001", cur());
      end
    end
    en = 1'b1;
    rise = -1; p = cur();
    for (int k = 1; k <= 30 && rise < 0; k++) begin
      @(negedge clk);
      if (mod && !p[6]) rise = k;
      p = cur();
    end
    checks++;
    if (rise < 0) begin
      failures++; $display("FAIL drain_restart got no mod rise want rise within 30");
    end
    en = 1'b0;
    repeat (3) @(negedge clk);
    en = 1'b1;
    mod_cnt = 0; run_ok = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      mod_cnt += int'(mod);
      if (running !== 1'b1) run_ok = 0;
    end
    checks++;
    if (!run_ok || mod_cnt != 10) begin
      failures++; $display("FAIL drain_reenable got run_ok=%0d mod_cnt=%0d want 1 10", run_ok, mod_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic [6:0] o, p;
    int rise;
    rise = -1; p = cur();
    for (int k = 1; k <= 30 && rise < 0; k++) begin
      @(negedge clk);
      if (mod && !p[6]) rise = k;
      p = cur();
    end
    cv = 1'b1; ch = 16'd3; cd = 16'd1; cp = {16'd0, 16'd0};
    @(negedge clk);
    cv = 1'b0;
    checks++;
    if (ready !== 1'b0) begin
      failures++; $display("FAIL rstmid_pending got ready=%b want=0", ready);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (cur() !== 7'b0000001) begin
      failures++; $display("FAIL rstmid_outputs got=%b want=0000001", cur());
    end
    rst = 1'b0;
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      o = cur();
      checks++;
      if (o[6] !== (k >= 4 && k <= 9) || o[5] !== (k >= 12 && k <= 17) || o[0] !== 1'b1) begin
        failures++;
        $display("FAIL rstmid_defaults k=%0d got mod,modn,rdy=%b%b%b want %b%b1", k, o[6], o[5],
                 o[0], k >= 4 && k <= 9, k >= 12 && k <= 17);
      end
    end
  endtask

  initial begin
    test_reset();
    test_default_run();
    test_cfg_change();
    test_illegal();
    test_back_to_back();
    test_drain();
    test_reset_mid();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nonoverlap_clkgen_multi.md
Name: nonoverlap_clkgen_multi

Overview:
Counter-based, run-time programmable generator for the modulation clock set: a non-overlapping complementary pair, CLK_OUT_MOD and CLK_OUT_MODN, plus NUM_LAG phase-shifted copies of MOD. It generalises the fixed-init shift-register generator. Half-period, dead time and per-lag phase are loaded through a valid/ready handshake and take effect only at a period boundary, so output glitches are impossible. It is fed by the selected frequency clock and drives the ODDR2 output buffers.

Parameters:
CNT_W, 16, width of half-period, dead-time and phase fields
NUM_LAG, 1, number of phase-shifted MOD copies (>=1)
DEF_HALF, 8, half-period in CLK_IN cycles, loaded at reset
DEF_DEAD, 2, dead time in cycles, loaded at reset
DEF_PHASE, 8, phase of every lag channel in cycles, loaded at reset

Ports:
CLK_IN  in  1  sole clock; all logic rising-edge
RESET  in  1  synchronous, active-high reset
ENABLE  in  1  level; run while high, stop at period end when low
CFG_VALID  in  1  new configuration offered
CFG_READY  out  1  shadow register empty, config can be accepted
CFG_HALF  in  CNT_W  half-period H
CFG_DEAD  in  CNT_W  dead time D
CFG_PHASE  in  NUM_LAG*CNT_W  lag phase P[i], channel i at bits [i*CNT_W +: CNT_W]
CLK_OUT_MOD  out  1  main phase
CLK_OUT_MODN  out  1  complementary non-overlapping phase
CLK_OUT_MODL  out  NUM_LAG  lagged copies of MOD
RUNNING  out  1  high in RUN and DRAIN
CFG_ERR  out  1  one-cycle pulse: offered config rejected

Behaviour:
- Reset, synchronous and active-high: state IDLE, cnt=0, active config = defaults, shadow empty.
- Reset output values: all clock outputs 0, RUNNING=0, CFG_ERR=0, CFG_READY=1.
- Reset asserted mid-operation overrides everything on the next edge. Any pending shadow config is discarded.
- Period is 2H cycles. cnt runs 0..2H-1 and wraps to 0.
- Decode:
  - MOD high when D <= cnt <= H-1.
  - MODN high when H+D <= cnt <= 2H-1.
  - MODL[i] high when ((cnt - P[i]) mod 2H) lies in [D, H-1]. Compute this with a CNT_W+1 bit subtract; add 2H if the result is negative.
- All clock outputs are registered: the output at cycle k+1 is the decode of cnt at cycle k. Latency is 1 cycle.
- MOD and MODN are never high in the same cycle. This holds for any legal config, including across a config change.
- Legal config: H>=1, D<H, every P[i] < 2H.
  - D=0 is legal: the pair has no dead time but still never overlaps.
- Handshake:
  - Transfer occurs when CFG_VALID & CFG_READY.
  - An illegal config still completes the handshake. It is discarded, and CFG_ERR pulses in the cycle after the transfer.
  - A legal config is stored in the shadow register, and CFG_READY drops next cycle.
- Apply rules:
  - In RUN, the shadow is copied to active on the wrap edge (cnt=2H-1 -> 0). The shadow empties and CFG_READY rises on the following cycle.
  - In IDLE, the shadow is applied on the next edge.
  - A transfer coinciding with the wrap edge is applied at the next wrap, not the current one.
- State machine:
  - IDLE: outputs forced 0, cnt held at 0. ENABLE=1 -> RUN with cnt=0 in the next cycle.
  - RUN: cnt counts. ENABLE=0 -> DRAIN.
  - DRAIN: cnt continues to 2H-1, then -> IDLE with cnt=0. If ENABLE=1 during DRAIN -> RUN with no restart, so cnt continues.
- RUNNING is registered: high in the cycle after entering RUN, low in the cycle after entering IDLE.

Test Plan:
- Reset defaults (H=8, D=2, P=8), ENABLE high at cycle t -> RUNNING=1 at t+2; MOD high cycles t+4..t+9, MODN high t+12..t+17, period 16; MODL equals MODN timing (P=H).
- Config H=4, D=1, P0=2 written while running -> applied at the next wrap only; new period 8; MOD high 3 of 8 cycles, MODN high 3 of 8; MODL0 rises 2 cycles after MOD; no MOD/MODN overlap at any cycle across the change.
- Illegal configs D=4/H=4 and P0=8/H=4 -> CFG_ERR one-cycle pulse each, active config unchanged, CFG_READY stays 1.
- Two back-to-back configs -> second held off (CFG_READY=0) until the first is applied at wrap; then accepted and applied at the following wrap.
- ENABLE dropped mid-period -> period completes, all outputs 0 from the wrap onward, RUNNING falls one cycle later; ENABLE re-asserted in DRAIN -> no gap in the waveform.
- RESET asserted mid-period with a shadow pending -> next cycle all outputs 0, defaults restored, pending config lost, CFG_READY=1.
